wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter INSTRET_W, default 64, width of the retired-instruction counter.
REQ-002 SHALL have ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- mem_valid_i  input  1  mem stage presents an instruction.
- wb_ready_o  output  1  stage can accept an instruction this cycle.
- mem_op_c_i  input  32  result value for non-loads.
- mem_reg_waddr_i  input  5  destination register.
- mem_reg_we_i  input  1  instruction writes a register.
- mem_load_i  input  1  instruction is a load.
- mem_load_type_i  input  3  load funct3.
- mem_addr_low_i  input  2  load byte address bits [1:0].
- dmem_rvalid_i  input  1  data-memory read response valid.
- dmem_rdata_i  input  32  data-memory read word.
- wb_op_c_o  output  32  write data to register file.
- wb_reg_waddr_o  output  5  write address to register file.
- wb_reg_we_o  output  1  write enable to register file.
- wb_instret_o  output  INSTRET_W  retired-instruction count.

Function
REQ-003 SHALL implement FSM with states IDLE and LOAD_WAIT; wb_ready_o SHALL be 1 exactly when in IDLE.
REQ-004 Transfer SHALL occur on a rising edge where mem_valid_i and wb_ready_o are both 1; no other input is sampled from the mem stage.
REQ-005 On transfer of a non-load: wb_op_c_o <= mem_op_c_i, wb_reg_waddr_o <= mem_reg_waddr_i, wb_reg_we_o <= mem_reg_we_i AND (mem_reg_waddr_i != 0); state stays IDLE. Write is visible to the register file one cycle after transfer.
REQ-006 On transfer of a load: waddr, we-qualifier, load type and addr_low SHALL be captured internally; wb_reg_we_o <= 0; state <= LOAD_WAIT.
REQ-007 In LOAD_WAIT, on an edge with dmem_rvalid_i=1: wb_op_c_o <= extended data (REQ-008), wb_reg_waddr_o <= captured waddr, wb_reg_we_o <= captured we AND (captured waddr != 0), state <= IDLE.
REQ-008 Load extension: byte = dmem_rdata_i[8*addr_low +: 8]; half = dmem_rdata_i[16*addr_low[1] +: 16], with addr_low[0] ignored; 000 LB sign-extend byte; 001 LH sign-extend half; 100 LBU zero-extend byte; 101 LHU zero-extend half; 010 and all other codes full word, addr_low ignored.
REQ-009 dmem_rvalid_i SHALL be ignored in IDLE, including in the cycle a load is transferred.
REQ-010 wb_reg_we_o SHALL be a one-cycle pulse per commit; on any edge without a commit, wb_reg_we_o <= 0; wb_op_c_o and wb_reg_waddr_o hold their last values.
REQ-011 Back-to-back non-load transfers SHALL commit on consecutive cycles with no bubble.
REQ-012 wb_instret_o SHALL increment by 1 on every commit edge (non-load transfer or load response in LOAD_WAIT), regardless of we or waddr; it SHALL wrap from all-ones to 0.
REQ-013 All outputs SHALL be registered; no combinational path from any input to any output except the FSM-state-derived wb_ready_o.

Reset
REQ-014 On rst_n=0, asynchronously: state=IDLE, wb_op_c_o=0, wb_reg_waddr_o=0, wb_reg_we_o=0, wb_instret_o=0, captured load fields=0.
REQ-015 Reset asserted in LOAD_WAIT SHALL abandon the load; a dmem_rvalid_i after reset release SHALL NOT cause a write.
REQ-016 wb_ready_o SHALL be 1 from reset onward until the first load transfer.

Verification
REQ-017 Non-load: transfer op_c=0x12345678, waddr=5, we=1 -> next cycle we=1, waddr=5, op_c=0x12345678; following cycle we=0; instret=1.
REQ-018 LB with rdata=0x80FF7F01 at addr_low=3 -> op_c=0xFFFFFF80; LBU at addr_low=1 -> 0x0000007F; LH at addr_low=2 -> 0xFFFF80FF; LHU at addr_low=0 -> 0x00007F01.
REQ-019 Load with rvalid held low 4 cycles: ready=0 and we=0 throughout, mem_valid_i ignored; rvalid at cycle 5 -> one write next cycle, ready=1.
REQ-020 waddr=0 with we=1 -> wb_reg_we_o stays 0; instret still increments.
REQ-021 Reset pulse in LOAD_WAIT followed by rvalid=1 -> no write, ready=1, instret=0.
REQ-022 Run with INSTRET_W=4: 16 commits -> wb_instret_o wraps from 15 to 0.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: commits ALU results directly and waits for data-memory responses on loads.
// Drives one register-file write per commit and counts retired instructions.
module wb_stage #(
    parameter int unsigned INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_valid_i,
    output logic                 wb_ready_o,
    input  logic [31:0]          mem_op_c_i,
    input  logic [4:0]           mem_reg_waddr_i,
    input  logic                 mem_reg_we_i,
    input  logic                 mem_load_i,
    input  logic [2:0]           mem_load_type_i,
    input  logic [1:0]           mem_addr_low_i,
    input  logic                 dmem_rvalid_i,
    input  logic [31:0]          dmem_rdata_i,
    output logic [31:0]          wb_op_c_o,
    output logic [4:0]           wb_reg_waddr_o,
    output logic                 wb_reg_we_o,
    output logic [INSTRET_W-1:0] wb_instret_o
);

    typedef enum logic {
        IDLE,
        LOAD_WAIT
    } state_e;

    state_e               state_q, state_d;
    logic [31:0]          op_c_q, op_c_d;
    logic [4:0]           waddr_q, waddr_d;
    logic                 we_q, we_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;
    logic [4:0]           ld_waddr_q, ld_waddr_d;
    logic                 ld_we_q, ld_we_d;
    logic [2:0]           ld_type_q, ld_type_d;
    logic [1:0]           ld_addr_q, ld_addr_d;

    logic [7:0]           ld_byte;
    logic [15:0]          ld_half;
    logic [31:0]          ld_data;

    // Lane select and sign/zero extension of the returned word
    always_comb begin
        ld_byte = dmem_rdata_i[7:0];
        case (ld_addr_q)
            2'd0: ld_byte = dmem_rdata_i[7:0];
            2'd1: ld_byte = dmem_rdata_i[15:8];
            2'd2: ld_byte = dmem_rdata_i[23:16];
            2'd3: ld_byte = dmem_rdata_i[31:24];
            default: ld_byte = dmem_rdata_i[7:0];
        endcase
        ld_half = ld_addr_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (ld_type_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h000000, ld_byte};
            3'b101:  ld_data = {16'h0000, ld_half};
            default: ld_data = dmem_rdata_i;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_c_d     = op_c_q;
        waddr_d    = waddr_q;
        we_d       = 1'b0;
        instret_d  = instret_q;
        ld_waddr_d = ld_waddr_q;
        ld_we_d    = ld_we_q;
        ld_type_d  = ld_type_q;
        ld_addr_d  = ld_addr_q;
        case (state_q)
            IDLE: begin
                if (mem_valid_i) begin
                    if (mem_load_i) begin
                        ld_waddr_d = mem_reg_waddr_i;
                        ld_we_d    = mem_reg_we_i;
                        ld_type_d  = mem_load_type_i;
                        ld_addr_d  = mem_addr_low_i;
                        state_d    = LOAD_WAIT;
                    end else begin
                        op_c_d    = mem_op_c_i;
                        waddr_d   = mem_reg_waddr_i;
                        we_d      = mem_reg_we_i & (|mem_reg_waddr_i);
                        instret_d = instret_q + INSTRET_W'(1);
                    end
                end
            end
            LOAD_WAIT: begin
                if (dmem_rvalid_i) begin
                    op_c_d    = ld_data;
                    waddr_d   = ld_waddr_q;
                    we_d      = ld_we_q & (|ld_waddr_q);
                    instret_d = instret_q + INSTRET_W'(1);
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_c_q     <= '0;
            waddr_q    <= '0;
            we_q       <= 1'b0;
            instret_q  <= '0;
            ld_waddr_q <= '0;
            ld_we_q    <= 1'b0;
            ld_type_q  <= '0;
            ld_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            op_c_q     <= op_c_d;
            waddr_q    <= waddr_d;
            we_q       <= we_d;
            instret_q  <= instret_d;
            ld_waddr_q <= ld_waddr_d;
            ld_we_q    <= ld_we_d;
            ld_type_q  <= ld_type_d;
            ld_addr_q  <= ld_addr_d;
        end
    end

    assign wb_ready_o     = (state_q == IDLE);
    assign wb_op_c_o      = op_c_q;
    assign wb_reg_waddr_o = waddr_q;
    assign wb_reg_we_o    = we_q;
    assign wb_instret_o   = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: stimulus pushes expected register writes into a scoreboard queue,
// a negedge monitor pops and compares every write the stage presents.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid_i = 1'b0;
    logic [31:0] mem_op_c_i = '0;
    logic [4:0]  mem_reg_waddr_i = '0;
    logic        mem_reg_we_i = 1'b0;
    logic        mem_load_i = 1'b0;
    logic [2:0]  mem_load_type_i = '0;
    logic [1:0]  mem_addr_low_i = '0;
    logic        dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;

    logic        wb_ready_o;
    logic [31:0] wb_op_c_o;
    logic [4:0]  wb_reg_waddr_o;
    logic        wb_reg_we_o;
    logic [63:0] wb_instret_o;

    logic        s_ready;
    logic [31:0] s_op_c;
    logic [4:0]  s_waddr;
    logic        s_we;
    logic [3:0]  s_instret;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;
    int unsigned exp_instret = 0;
    logic [36:0] sb_q[$];

    always #5 clk = ~clk;

    wb_stage #(.INSTRET_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .mem_valid_i(mem_valid_i), .wb_ready_o(wb_ready_o),
        .mem_op_c_i(mem_op_c_i), .mem_reg_waddr_i(mem_reg_waddr_i), .mem_reg_we_i(mem_reg_we_i),
        .mem_load_i(mem_load_i), .mem_load_type_i(mem_load_type_i), .mem_addr_low_i(mem_addr_low_i),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .wb_op_c_o(wb_op_c_o),
        .wb_reg_waddr_o(wb_reg_waddr_o), .wb_reg_we_o(wb_reg_we_o), .wb_instret_o(wb_instret_o)
    );

    wb_stage #(.INSTRET_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .mem_valid_i(mem_valid_i), .wb_ready_o(s_ready),
        .mem_op_c_i(mem_op_c_i), .mem_reg_waddr_i(mem_reg_waddr_i), .mem_reg_we_i(mem_reg_we_i),
        .mem_load_i(mem_load_i), .mem_load_type_i(mem_load_type_i), .mem_addr_low_i(mem_addr_low_i),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .wb_op_c_o(s_op_c),
        .wb_reg_waddr_o(s_waddr), .wb_reg_we_o(s_we), .wb_instret_o(s_instret)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (rst_n && wb_reg_we_o) begin
            compared++;
            if (sb_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_write: got waddr=%0d data=0x%08h expected no write",
                         wb_reg_waddr_o, wb_op_c_o);
            end else begin
                logic [36:0] e;
                e = sb_q.pop_front();
                if ({wb_reg_waddr_o, wb_op_c_o} !== e) begin
                    mismatched++;
                    $display("FAIL write_data: got waddr=%0d data=0x%08h expected waddr=%0d data=0x%08h",
                             wb_reg_waddr_o, wb_op_c_o, e[36:32], e[31:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_valid_i   = 1'b0;
        mem_load_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
    endtask

    // Leaves mem_valid_i asserted so consecutive calls form a back-to-back stream
    task automatic send_alu(input logic [31:0] opc, input logic [4:0] wa, input logic we);
        check("alu_ready", {63'd0, wb_ready_o}, 64'd1);
        mem_valid_i     = 1'b1;
        mem_load_i      = 1'b0;
        mem_op_c_i      = opc;
        mem_reg_waddr_i = wa;
        mem_reg_we_i    = we;
        if (we && wa != 5'd0) sb_q.push_back({wa, opc});
        exp_instret++;
        step();
    endtask

    task automatic send_load(input logic [2:0] ty, input logic [1:0] al, input logic [4:0] wa,
                             input logic we, input logic [31:0] rdata, input logic [31:0] exp,
                             input int unsigned delay);
        mem_valid_i     = 1'b1;
        mem_load_i      = 1'b1;
        mem_load_type_i = ty;
        mem_addr_low_i  = al;
        mem_reg_waddr_i = wa;
        mem_reg_we_i    = we;
        mem_op_c_i      = 32'h0BADF00D;
        dmem_rvalid_i   = 1'b1;
        dmem_rdata_i    = 32'hDEADBEEF;
        step();
        check("load_ready_low", {63'd0, wb_ready_o}, 64'd0);
        // Garbage offered by the mem stage while waiting must be ignored
        mem_load_i      = 1'b0;
        mem_op_c_i      = 32'hBAD0BAD0;
        mem_reg_waddr_i = 5'd7;
        mem_reg_we_i    = 1'b1;
        mem_load_type_i = 3'b010;
        mem_addr_low_i  = 2'd0;
        dmem_rvalid_i   = 1'b0;
        for (int unsigned i = 0; i < delay; i++) begin
            step();
            check("wait_ready", {63'd0, wb_ready_o}, 64'd0);
            check("wait_we", {63'd0, wb_reg_we_o}, 64'd0);
        end
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = rdata;
        if (we && wa != 5'd0) sb_q.push_back({wa, exp});
        exp_instret++;
        step();
        idle_inputs();
        check("load_done_ready", {63'd0, wb_ready_o}, 64'd1);
        check("load_instret", wb_instret_o, 64'(exp_instret));
    endtask

    initial begin
        #2;
        check("rst_ready", {63'd0, wb_ready_o}, 64'd1);
        check("rst_we", {63'd0, wb_reg_we_o}, 64'd0);
        check("rst_op_c", {32'd0, wb_op_c_o}, 64'd0);
        check("rst_waddr", {59'd0, wb_reg_waddr_o}, 64'd0);
        check("rst_instret", wb_instret_o, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        send_alu(32'h12345678, 5'd5, 1'b1);
        idle_inputs();
        check("alu_we_pulse", {63'd0, wb_reg_we_o}, 64'd1);
        step();
        check("alu_we_drop", {63'd0, wb_reg_we_o}, 64'd0);
        check("alu_op_hold", {32'd0, wb_op_c_o}, 64'h12345678);
        check("alu_instret", wb_instret_o, 64'd1);

        send_alu(32'hCAFEF00D, 5'd0, 1'b1);
        idle_inputs();
        step();
        check("x0_instret", wb_instret_o, 64'd2);

        send_load(3'b000, 2'd3, 5'd10, 1'b1, 32'h80FF7F01, 32'hFFFFFF80, 0);
        send_load(3'b100, 2'd1, 5'd11, 1'b1, 32'h80FF7F01, 32'h0000007F, 1);
        send_load(3'b001, 2'd2, 5'd12, 1'b1, 32'h80FF7F01, 32'hFFFF80FF, 4);
        send_load(3'b101, 2'd0, 5'd13, 1'b1, 32'h80FF7F01, 32'h00007F01, 2);
        send_load(3'b001, 2'd3, 5'd14, 1'b1, 32'h80FF7F01, 32'hFFFF80FF, 0);
        send_load(3'b101, 2'd1, 5'd15, 1'b1, 32'h80FF7F01, 32'h00007F01, 0);
        send_load(3'b010, 2'd3, 5'd16, 1'b1, 32'h80FF7F01, 32'h80FF7F01, 0);
        send_load(3'b011, 2'd2, 5'd17, 1'b1, 32'h80FF7F01, 32'h80FF7F01, 0);
        send_load(3'b000, 2'd0, 5'd0, 1'b1, 32'h000000FF, 32'hFFFFFFFF, 1);
        send_load(3'b100, 2'd2, 5'd18, 1'b0, 32'h00AB0000, 32'h000000AB, 0);

        send_alu(32'h00000001, 5'd1, 1'b1);
        send_alu(32'h00000002, 5'd2, 1'b1);
        send_alu(32'h00000003, 5'd3, 1'b1);
        idle_inputs();
        check("b2b_we", {63'd0, wb_reg_we_o}, 64'd1);
        check("b2b_waddr", {59'd0, wb_reg_waddr_o}, 64'd3);
        step();
        check("b2b_instret", wb_instret_o, 64'(exp_instret));

        // Abandon a pending load with an async reset pulse
        mem_valid_i     = 1'b1;
        mem_load_i      = 1'b1;
        mem_reg_waddr_i = 5'd20;
        mem_reg_we_i    = 1'b1;
        mem_load_type_i = 3'b010;
        step();
        idle_inputs();
        check("pre_rst_ready", {63'd0, wb_ready_o}, 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ready", {63'd0, wb_ready_o}, 64'd1);
        check("async_rst_instret", wb_instret_o, 64'd0);
        exp_instret = 0;
        step();
        rst_n = 1'b1;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h55555555;
        step();
        step();
        dmem_rvalid_i = 1'b0;
        check("post_rst_ready", {63'd0, wb_ready_o}, 64'd1);
        check("post_rst_instret", wb_instret_o, 64'd0);

        for (int unsigned i = 0; i < 15; i++) send_alu(32'h100 + i, 5'd9, 1'b1);
        idle_inputs();
        step();
        check("wrap_at_15", {60'd0, s_instret}, 64'd15);
        send_alu(32'h0000FFFF, 5'd9, 1'b1);
        idle_inputs();
        step();
        check("wrap_to_0", {60'd0, s_instret}, 64'd0);
        check("wide_no_wrap", wb_instret_o, 64'd16);

        step();
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
